// File: rtl/mem_arb.sv
//==============================================================================
// Module      : mem_arb
// Description : Round-robin arbiter that shares one byte-addressed data memory
//               (combinational read port, byte-enabled clocked write port)
//               between NUM_REQ requesters. One transaction is granted per
//               cycle. Each granted request receives a registered response one
//               cycle after its handshake. Out-of-range accesses are blocked
//               here and answered with an error response.
//
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               req_valid/ready   - per-requester request handshake
//               req_wr            - 1 = write, 0 = read
//               req_addr/wdata/be - flattened request fields (slot i at i*W)
//               rsp_valid/ready   - per-requester response handshake
//               rsp_rdata/err     - flattened read data, error flag
//               mem_*             - memory read port and write port
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arb #(
    parameter int NUM_REQ   = 2,
    parameter int MEM_BYTES = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    input  logic [4*NUM_REQ-1:0]  req_be,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [32*NUM_REQ-1:0] rsp_rdata,
    output logic [NUM_REQ-1:0]    rsp_err,
    output logic [31:0]           mem_adrs_rd,
    input  logic [31:0]           mem_rd_data,
    output logic                  mem_wr_en,
    output logic [3:0]            mem_byt_en,
    output logic [31:0]           mem_adrs_wr,
    output logic [31:0]           mem_wr_data
);

    localparam int                 c_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0]        c_LAST_ADDR = 32'(MEM_BYTES - 4);
    localparam logic [c_IDX_W-1:0] c_RST_GRANT = c_IDX_W'(NUM_REQ - 1);

    // Registered state
    logic [c_IDX_W-1:0]    r_last_grant;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [NUM_REQ-1:0]    r_rsp_err;
    logic [32*NUM_REQ-1:0] r_rsp_rdata;

    // Unpacked request fields
    logic [31:0]        w_addr  [NUM_REQ];
    logic [31:0]        w_wdata [NUM_REQ];
    logic [3:0]         w_be    [NUM_REQ];
    logic [NUM_REQ-1:0] w_eligible;

    // Arbitration result and selected request
    logic               w_grant_any;
    logic [c_IDX_W-1:0] w_grant_idx;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic [3:0]         w_sel_be;
    logic               w_sel_wr;
    logic               w_in_range;
    logic               w_do_read;
    logic               w_do_write;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr[32*gi +: 32];
            assign w_wdata[gi] = req_wdata[32*gi +: 32];
            assign w_be[gi]    = req_be[4*gi +: 4];
            // A response slot being drained this cycle is already free.
            assign w_eligible[gi] = req_valid[gi] & (~r_rsp_valid[gi] | rsp_ready[gi]);
        end
    endgenerate

    // Round-robin search starting at last_grant+1. Offsets are scanned from
    // the farthest to the nearest so the nearest eligible requester is the
    // last assignment and therefore wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = r_last_grant;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (w_eligible[(int'(r_last_grant) + off) % NUM_REQ]) begin
                w_grant_any = 1'b1;
                w_grant_idx = c_IDX_W'((int'(r_last_grant) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_any) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_sel_addr  = w_addr[w_grant_idx];
    assign w_sel_wdata = w_wdata[w_grant_idx];
    assign w_sel_be    = w_be[w_grant_idx];
    assign w_sel_wr    = req_wr[w_grant_idx];
    assign w_in_range  = (w_sel_addr <= c_LAST_ADDR);
    assign w_do_read   = w_grant_any & ~w_sel_wr & w_in_range;
    assign w_do_write  = w_grant_any &  w_sel_wr & w_in_range;

    // Memory ports are driven only for an in-range handshake; otherwise zero.
    assign mem_adrs_rd = w_do_read  ? w_sel_addr  : 32'h0;
    assign mem_wr_en   = w_do_write;
    assign mem_byt_en  = w_do_write ? w_sel_be    : 4'h0;
    assign mem_adrs_wr = w_do_write ? w_sel_addr  : 32'h0;
    assign mem_wr_data = w_do_write ? w_sel_wdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_RST_GRANT;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_idx;
        end
    end

    // Response slots: a new handshake reloads the slot (even while it is being
    // drained), a drained slot clears, and an unconsumed slot holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    r_rsp_valid[i]         <= 1'b1;
                    r_rsp_err[i]           <= ~w_in_range;
                    r_rsp_rdata[32*i +: 32] <= w_do_read ? mem_rd_data : 32'h0;
                end else if (rsp_ready[i]) begin
                    r_rsp_valid[i]         <= 1'b0;
                    r_rsp_err[i]           <= 1'b0;
                    r_rsp_rdata[32*i +: 32] <= 32'h0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
//==============================================================================
// Module      : tb_mem_arb
// Description : Directed self-checking bench for mem_arb (NUM_REQ=2,
//               MEM_BYTES=128) with a byte-addressed memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arb;

    localparam int c_NUM_REQ   = 2;
    localparam int c_MEM_BYTES = 128;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] mem_adrs_rd;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [3:0]  mem_byt_en;
    logic [31:0] mem_adrs_wr;
    logic [31:0] mem_wr_data;

    logic [7:0]  tb_mem [0:c_MEM_BYTES-1];

    int checks = 0;
    int errors = 0;

    mem_arb #(
        .NUM_REQ   (c_NUM_REQ),
        .MEM_BYTES (c_MEM_BYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_adrs_rd (mem_adrs_rd),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_byt_en  (mem_byt_en),
        .mem_adrs_wr (mem_adrs_wr),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational little-endian read, byte-enabled write.
    always_comb begin
        mem_rd_data = 32'h0;
        if (mem_adrs_rd <= 32'(c_MEM_BYTES - 4)) begin
            mem_rd_data = {tb_mem[mem_adrs_rd + 3], tb_mem[mem_adrs_rd + 2],
                           tb_mem[mem_adrs_rd + 1], tb_mem[mem_adrs_rd]};
        end
    end

    always @(posedge clk) begin
        if (mem_wr_en && mem_adrs_wr <= 32'(c_MEM_BYTES - 4)) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_byt_en[k]) tb_mem[mem_adrs_wr + 32'(k)] <= mem_wr_data[8*k +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        req_valid[i]          = v;
        req_wr[i]             = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_be[4*i +: 4]      = be;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;

        rst_n     = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 2'b11;
        for (int b = 0; b < c_MEM_BYTES; b++) tb_mem[b] = 8'h00;
        tb_mem[32'h20] = 8'h44;
        tb_mem[32'h21] = 8'h33;
        tb_mem[32'h22] = 8'h22;
        tb_mem[32'h23] = 8'h11;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_err",   32'(rsp_err),   32'h0);
        check("rst_rdata0",    rsp_rdata[31:0],  32'h0);
        check("rst_rdata1",    rsp_rdata[63:32], 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("idle_wr_en",    32'(mem_wr_en), 32'h0);
        rst_n = 1'b1;

        // Full write then read-back
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #4;
        check("wr_ready",   32'(req_ready),  32'h1);
        check("wr_en",      32'(mem_wr_en),  32'h1);
        check("wr_adrs",    mem_adrs_wr,     32'h10);
        check("wr_data",    mem_wr_data,     32'hDEADBEEF);
        check("wr_be",      32'(mem_byt_en), 32'hF);
        next_cycle();
        check("wr_rsp_valid", 32'(rsp_valid),  32'h1);
        check("wr_rsp_rdata", rsp_rdata[31:0], 32'h0);
        check("wr_rsp_err",   32'(rsp_err),    32'h0);
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #4;
        check("rd_adrs",  mem_adrs_rd,    32'h10);
        check("rd_wr_en", 32'(mem_wr_en), 32'h0);
        next_cycle();
        check("rd_rsp_valid", 32'(rsp_valid),  32'h1);
        check("rd_rsp_rdata", rsp_rdata[31:0], 32'hDEADBEEF);

        // Partial write: bytes 0x21 and 0x22 only
        set_req(0, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h6);
        #4;
        check("pw_be", 32'(mem_byt_en), 32'h6);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        next_cycle();
        check("pw_readback", rsp_rdata[31:0], 32'h11BBCC44);

        // Zero byte-enable write: still acknowledged, memory unchanged
        set_req(0, 1'b1, 1'b1, 32'h10, 32'h00000000, 4'h0);
        #4;
        check("be0_wr_en", 32'(mem_wr_en),  32'h1);
        check("be0_be",    32'(mem_byt_en), 32'h0);
        next_cycle();
        check("be0_rsp_valid", 32'(rsp_valid), 32'h1);
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        next_cycle();
        check("be0_readback", rsp_rdata[31:0], 32'hDEADBEEF);

        // Round-robin: last grant was requester 0, so requester 1 leads
        set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        for (int c = 0; c < 6; c++) begin
            exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
            #4;
            check($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(exp_g));
            next_cycle();
            check($sformatf("rr_rsp_valid_%0d", c), 32'(rsp_valid), 32'(exp_g));
            if (exp_g[1]) check($sformatf("rr_rdata1_%0d", c), rsp_rdata[63:32], 32'h11BBCC44);
            else          check($sformatf("rr_rdata0_%0d", c), rsp_rdata[31:0],  32'hDEADBEEF);
        end

        // Backpressure on requester 1
        rsp_ready = 2'b01;
        #4;
        check("bp_first_grant", 32'(req_ready), 32'h2);
        next_cycle();
        check("bp_first_rsp", 32'(rsp_valid), 32'h2);
        set_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            #4;
            check($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'h1);
            next_cycle();
            check($sformatf("bp_valid_%0d", c), 32'(rsp_valid), 32'h3);
            check($sformatf("bp_hold1_%0d", c), rsp_rdata[63:32], 32'h11BBCC44);
        end
        rsp_ready = 2'b11;
        #4;
        check("bp_regrant", 32'(req_ready), 32'h2);
        next_cycle();
        check("bp_regrant_valid", 32'(rsp_valid), 32'h2);
        check("bp_regrant_rdata", rsp_rdata[63:32], 32'hDEADBEEF);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Out of range write at 0x7D
        set_req(0, 1'b1, 1'b1, 32'h7D, 32'hCAFEF00D, 4'hF);
        #4;
        check("oor_ready", 32'(req_ready),  32'h1);
        check("oor_wr_en", 32'(mem_wr_en),  32'h0);
        check("oor_be",    32'(mem_byt_en), 32'h0);
        next_cycle();
        check("oor_valid", 32'(rsp_valid), 32'h1);
        check("oor_err",   32'(rsp_err),   32'h1);
        check("oor_rdata", rsp_rdata[31:0], 32'h0);
        check("oor_mem", {tb_mem[127], tb_mem[126], tb_mem[125], tb_mem[124]}, 32'h0);

        // Last legal word at 0x7C
        set_req(0, 1'b1, 1'b1, 32'h7C, 32'h01020304, 4'hF);
        #4;
        check("edge_wr_en", 32'(mem_wr_en), 32'h1);
        check("edge_adrs",  mem_adrs_wr,    32'h7C);
        next_cycle();
        check("edge_err", 32'(rsp_err), 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h7C, 32'h0, 4'h0);
        next_cycle();
        check("edge_rdata", rsp_rdata[31:0], 32'h01020304);
        set_req(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        next_cycle();
        check("oor_rd_err",   32'(rsp_err),    32'h1);
        check("oor_rd_rdata", rsp_rdata[31:0], 32'h0);

        // Asynchronous reset while a response is held
        rsp_ready = 2'b00;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        next_cycle();
        check("ar_pre_valid", 32'(rsp_valid), 32'h1);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_cleared", 32'(rsp_valid),  32'h0);
        check("ar_rdata_cleared", rsp_rdata[31:0], 32'h0);
        next_cycle();
        rst_n     = 1'b1;
        rsp_ready = 2'b11;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        #4;
        check("ar_first_grant", 32'(req_ready), 32'h1);
        next_cycle();
        check("ar_first_rsp", 32'(rsp_valid), 32'h1);
        #4;
        check("ar_second_grant", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
